// File: rtl/rv_iopmp_entry_walker.sv
// Sequential IOPMP rule checker: walks the entry BRAM for one request at a time.
// Define RV_IOPMP_NAPOT_EN to enable NA4/NAPOT address matching (otherwise those modes never match).
module rv_iopmp_entry_walker #(
    parameter int unsigned NUMBER_MDS     = 2,
    parameter int unsigned NUMBER_ENTRIES = 8,
    parameter int unsigned NUMBER_MASTERS = 2,
    parameter int unsigned RID_WIDTH      = 8
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              iopmp_enabled_i,
    input  logic [15:0]                       nr_prio_entry_i,
    input  logic [NUMBER_MDS*16-1:0]          mdcfg_t_i,
    input  logic [NUMBER_MASTERS*NUMBER_MDS-1:0] srcmd_md_i,
    input  logic                              req_valid_i,
    output logic                              req_ready_o,
    input  logic [63:0]                       req_addr_i,
    input  logic [RID_WIDTH-1:0]              req_rid_i,
    input  logic [1:0]                        req_ttype_i,
    output logic                              bram_en_o,
    output logic [$clog2(NUMBER_ENTRIES)-1:0] bram_addr_o,
    input  logic [127:0]                      bram_dout_i,
    output logic                              rsp_valid_o,
    input  logic                              rsp_ready_i,
    output logic                              rsp_allow_o,
    output logic [3:0]                        rsp_etype_o,
    output logic [15:0]                       rsp_entry_o
);

    localparam int unsigned         IDXW     = $clog2(NUMBER_ENTRIES);
    localparam logic [IDXW-1:0]     LAST_IDX = IDXW'(NUMBER_ENTRIES - 1);
    localparam logic [15:0]         NE16     = 16'(NUMBER_ENTRIES);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_EVAL, S_RESP} state_e;

    state_e                 state_q, state_d;
    logic [63:0]            addr_q, addr_d;
    logic                   wr_q, wr_d;
    logic [NUMBER_MDS-1:0]  mdmap_q, mdmap_d;
    logic [IDXW-1:0]        idx_q, idx_d;
    logic [63:0]            prev_q, prev_d;
    logic                   miss_q, miss_d;
    logic                   allow_q, allow_d;
    logic [3:0]             etype_q, etype_d;
    logic [15:0]            entry_q, entry_d;

    logic                   rid_ok;
    logic [NUMBER_MDS-1:0]  rid_map;
    logic [NUMBER_MDS-1:0]  owns;
    logic [15:0]            idx16, md_lo, md_hi;
    logic [63:0]            ent_e;
    logic [1:0]             amode;
    logic                   perm, tor_hit, match, in_md, hit, is_prio;
    logic                   unused_bits;

    function automatic logic [15:0] clamp_top(input logic [15:0] t);
        return (t > NE16) ? NE16 : t;
    endfunction

    assign unused_bits = ^{bram_dout_i[127:69], bram_dout_i[66], req_addr_i[1:0]};

    assign idx16   = 16'(idx_q);
    assign ent_e   = bram_dout_i[63:0];
    assign amode   = bram_dout_i[68:67];
    assign perm    = wr_q ? bram_dout_i[65] : bram_dout_i[64];
    assign tor_hit = (prev_q <= addr_q) && (addr_q < ent_e);
    assign is_prio = idx16 < nr_prio_entry_i;
    assign in_md   = |(mdmap_q & owns);
    assign hit     = in_md & match;

    always_comb begin
        rid_ok  = 32'(req_rid_i) < 32'(NUMBER_MASTERS);
        rid_map = '0;
        for (int unsigned r = 0; r < NUMBER_MASTERS; r++) begin
            if (32'(req_rid_i) == r) rid_map = srcmd_md_i[r*NUMBER_MDS +: NUMBER_MDS];
        end
    end

    // MD m owns [top(m-1), top(m)); each top is clamped to the BRAM depth.
    always_comb begin
        owns  = '0;
        md_lo = '0;
        md_hi = '0;
        for (int unsigned m = 0; m < NUMBER_MDS; m++) begin
            md_hi   = clamp_top(mdcfg_t_i[m*16 +: 16]);
            owns[m] = (idx16 >= md_lo) && (idx16 < md_hi);
            md_lo   = md_hi;
        end
    end

`ifdef RV_IOPMP_NAPOT_EN
    logic [63:0] napot_mask;
    // Trailing ones of E plus the first zero above them are "don't care" bits.
    assign napot_mask = ent_e ^ (ent_e + 64'd1);
`endif

    always_comb begin
        match = 1'b0;
        case (amode)
            2'd1:    match = tor_hit;
`ifdef RV_IOPMP_NAPOT_EN
            2'd2:    match = (addr_q == ent_e);
            2'd3:    match = ((addr_q ^ ent_e) & ~napot_mask) == '0;
`endif
            default: match = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            mdmap_q <= '0;
            idx_q   <= '0;
            prev_q  <= '0;
            miss_q  <= 1'b0;
            allow_q <= 1'b0;
            etype_q <= '0;
            entry_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            mdmap_q <= mdmap_d;
            idx_q   <= idx_d;
            prev_q  <= prev_d;
            miss_q  <= miss_d;
            allow_q <= allow_d;
            etype_q <= etype_d;
            entry_q <= entry_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wr_d        = wr_q;
        mdmap_d     = mdmap_q;
        idx_d       = idx_q;
        prev_d      = prev_q;
        miss_d      = miss_q;
        allow_d     = allow_q;
        etype_d     = etype_q;
        entry_d     = entry_q;
        bram_en_o   = 1'b0;
        bram_addr_o = '0;

        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    addr_d  = {2'b00, req_addr_i[63:2]};
                    wr_d    = (req_ttype_i == 2'd2);
                    mdmap_d = rid_map;
                    idx_d   = '0;
                    prev_d  = '0;
                    miss_d  = 1'b0;
                    allow_d = 1'b0;
                    entry_d = '0;
                    if (!rid_ok) begin
                        etype_d = 4'h6;
                        state_d = S_RESP;
                    end else if (!iopmp_enabled_i) begin
                        etype_d = 4'h5;
                        state_d = S_RESP;
                    end else begin
                        etype_d = '0;
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                bram_en_o   = 1'b1;
                bram_addr_o = idx_q;
                state_d     = S_EVAL;
            end
            S_EVAL: begin
                prev_d = ent_e;
                if (hit && perm) begin
                    allow_d = 1'b1;
                    etype_d = '0;
                    entry_d = idx16;
                    state_d = S_RESP;
                end else if (hit && is_prio) begin
                    allow_d = 1'b0;
                    etype_d = wr_q ? 4'h2 : 4'h1;
                    entry_d = idx16;
                    state_d = S_RESP;
                end else begin
                    miss_d = miss_q | hit;
                    if (idx_q == LAST_IDX) begin
                        allow_d = 1'b0;
                        etype_d = (miss_q | hit) ? (wr_q ? 4'h2 : 4'h1) : 4'h5;
                        entry_d = '0;
                        state_d = S_RESP;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_RD;
                    end
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                    prev_d  = '0;
                    idx_d   = '0;
                    miss_d  = 1'b0;
                    allow_d = 1'b0;
                    etype_d = '0;
                    entry_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign req_ready_o = (state_q == S_IDLE) && rst_ni;
    assign rsp_valid_o = (state_q == S_RESP);
    assign rsp_allow_o = allow_q;
    assign rsp_etype_o = etype_q;
    assign rsp_entry_o = entry_q;

endmodule

// File: tb/tb_rv_iopmp_entry_walker.sv
// Directed bench for rv_iopmp_entry_walker with a registered BRAM model and an expectation queue.
module tb_rv_iopmp_entry_walker;

    localparam int unsigned NMD = 2;
    localparam int unsigned NE  = 8;
    localparam int unsigned NM  = 2;
    localparam int unsigned RW  = 8;

    logic                  clk_i = 1'b0;
    logic                  rst_ni;
    logic                  iopmp_enabled_i;
    logic [15:0]           nr_prio_entry_i;
    logic [NMD*16-1:0]     mdcfg_t_i;
    logic [NM*NMD-1:0]     srcmd_md_i;
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic [63:0]           req_addr_i;
    logic [RW-1:0]         req_rid_i;
    logic [1:0]            req_ttype_i;
    logic                  bram_en_o;
    logic [$clog2(NE)-1:0] bram_addr_o;
    logic [127:0]          bram_dout_i = '0;
    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic                  rsp_allow_o;
    logic [3:0]            rsp_etype_o;
    logic [15:0]           rsp_entry_o;

    always #5 clk_i = ~clk_i;

    rv_iopmp_entry_walker #(
        .NUMBER_MDS(NMD), .NUMBER_ENTRIES(NE), .NUMBER_MASTERS(NM), .RID_WIDTH(RW)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .iopmp_enabled_i(iopmp_enabled_i),
        .nr_prio_entry_i(nr_prio_entry_i), .mdcfg_t_i(mdcfg_t_i), .srcmd_md_i(srcmd_md_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
        .req_rid_i(req_rid_i), .req_ttype_i(req_ttype_i), .bram_en_o(bram_en_o),
        .bram_addr_o(bram_addr_o), .bram_dout_i(bram_dout_i), .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready_i), .rsp_allow_o(rsp_allow_o), .rsp_etype_o(rsp_etype_o),
        .rsp_entry_o(rsp_entry_o)
    );

    logic [127:0] mem [NE];
    always @(posedge clk_i) if (bram_en_o) bram_dout_i <= mem[bram_addr_o];

    int unsigned cyc = 0;
    int unsigned en_cnt = 0;
    always @(posedge clk_i) begin
        cyc <= cyc + 1;
        if (bram_en_o) en_cnt <= en_cnt + 1;
    end

    typedef struct {
        logic        allow;
        logic [3:0]  etype;
        logic [15:0] entry;
        int unsigned lat;
    } exp_t;
    exp_t sb[$];

    int ntests = 0;
    int nfail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] mk(input logic [63:0] e, input logic r, input logic w,
                                        input logic [1:0] a);
        logic [127:0] v;
        v = '0;
        v[63:0]  = e;
        v[64]    = r;
        v[65]    = w;
        v[68:67] = a;
        return v;
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < NE; i++) mem[i] = '0;
    endtask

    task automatic do_req(input string tag, input logic [63:0] addr, input logic [7:0] rid,
                          input logic [1:0] tt, input logic ea, input logic [3:0] ee,
                          input logic [15:0] ent, input int unsigned lat, input int unsigned hold);
        exp_t e, got;
        int unsigned h, en0;
        bit seen;
        e.allow = ea; e.etype = ee; e.entry = ent; e.lat = lat;
        sb.push_back(e);
        @(negedge clk_i);
        rsp_ready_i = (hold == 0);
        req_valid_i = 1'b1;
        req_addr_i  = addr;
        req_rid_i   = rid;
        req_ttype_i = tt;
        check({tag, ":req_ready"}, 64'(req_ready_o), 64'd1);
        en0 = en_cnt;
        @(posedge clk_i); #1;
        h = cyc - 1;
        req_valid_i = 1'b0;
        seen = rsp_valid_o;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk_i); #1;
            seen = rsp_valid_o;
        end
        check({tag, ":rsp_seen"}, 64'(seen), 64'd1);
        got = sb.pop_front();
        if (seen) begin
            check({tag, ":latency"}, 64'(cyc - h), 64'(got.lat));
            check({tag, ":allow"}, 64'(rsp_allow_o), 64'(got.allow));
            check({tag, ":etype"}, 64'(rsp_etype_o), 64'(got.etype));
            check({tag, ":entry"}, 64'(rsp_entry_o), 64'(got.entry));
            if (lat == 1) check({tag, ":no_bram"}, 64'(en_cnt), 64'(en0));
            for (int i = 0; i < hold; i++) begin
                @(posedge clk_i); #1;
                check({tag, ":hold_valid"}, 64'(rsp_valid_o), 64'd1);
                check({tag, ":hold_etype"}, 64'(rsp_etype_o), 64'(got.etype));
                check({tag, ":hold_allow"}, 64'(rsp_allow_o), 64'(got.allow));
                check({tag, ":hold_ready"}, 64'(req_ready_o), 64'd0);
            end
            if (hold != 0) begin
                @(negedge clk_i);
                rsp_ready_i = 1'b1;
            end
            @(posedge clk_i); #1;
            check({tag, ":rsp_done"}, 64'(rsp_valid_o), 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0;
        iopmp_enabled_i = 1'b1;
        nr_prio_entry_i = '0;
        mdcfg_t_i = '0;
        srcmd_md_i = '0;
        req_valid_i = 1'b0;
        req_addr_i = '0;
        req_rid_i = '0;
        req_ttype_i = '0;
        rsp_ready_i = 1'b1;
        clear_mem();

        repeat (2) @(posedge clk_i);
        #1;
        check("rst:req_ready", 64'(req_ready_o), 64'd0);
        check("rst:rsp_valid", 64'(rsp_valid_o), 64'd0);
        check("rst:bram_en", 64'(bram_en_o), 64'd0);
        check("rst:allow", 64'(rsp_allow_o), 64'd0);
        check("rst:etype", 64'(rsp_etype_o), 64'd0);
        check("rst:entry", 64'(rsp_entry_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        check("idle:req_ready", 64'(req_ready_o), 64'd1);

        // TOR entry 0 = [0, 0x1000) bytes, read-only, MD0 owns entry 0, RID0->MD0, RID1->MD0+MD1
        mem[0] = mk(64'h400, 1'b1, 1'b0, 2'd1);
        mdcfg_t_i = {16'd8, 16'd1};
        srcmd_md_i = {2'b11, 2'b01};
        nr_prio_entry_i = 16'd1;
        do_req("prio_rd",    64'h800,  8'd0, 2'd1, 1'b1, 4'h0, 16'd0, 3,  0);
        do_req("prio_wr",    64'h800,  8'd0, 2'd2, 1'b0, 4'h2, 16'd0, 3,  0);
        do_req("bad_rid",    64'h800,  8'd5, 2'd1, 1'b0, 4'h6, 16'd0, 1,  0);
        iopmp_enabled_i = 1'b0;
        do_req("disabled",   64'h800,  8'd0, 2'd1, 1'b0, 4'h5, 16'd0, 1,  0);
        iopmp_enabled_i = 1'b1;
        do_req("ttype3",     64'h800,  8'd0, 2'd3, 1'b1, 4'h0, 16'd0, 3,  0);
        do_req("tor_top",    64'h1000, 8'd0, 2'd1, 1'b0, 4'h5, 16'd0, 17, 0);

        nr_prio_entry_i = 16'd0;
        do_req("np_rd",      64'h800,  8'd0, 2'd1, 1'b1, 4'h0, 16'd0, 3,  0);
        do_req("np_wr_miss", 64'h800,  8'd0, 2'd2, 1'b0, 4'h2, 16'd0, 17, 0);

        clear_mem();
        do_req("all_off",    64'h800,  8'd0, 2'd1, 1'b0, 4'h5, 16'd0, 17, 5);

        // Entry 3 is in MD1 only; nr_prio beyond depth makes every entry priority
        mem[3] = mk(64'h400, 1'b0, 1'b1, 2'd1);
        nr_prio_entry_i = 16'd16;
        do_req("md_skip",    64'h800,  8'd0, 2'd2, 1'b0, 4'h5, 16'd0, 17, 0);
        do_req("md_hit",     64'h800,  8'd1, 2'd2, 1'b1, 4'h0, 16'd3, 9,  0);
        do_req("prio_deny3", 64'h800,  8'd1, 2'd1, 1'b0, 4'h1, 16'd3, 9,  0);

        // OFF entry 0 still sets P=0x100 for TOR entry 1; MD1 top is clamped
        clear_mem();
        mem[0] = mk(64'h100, 1'b1, 1'b1, 2'd0);
        mem[1] = mk(64'h400, 1'b1, 1'b0, 2'd1);
        mdcfg_t_i = {16'hFFFF, 16'd1};
        nr_prio_entry_i = 16'd0;
        do_req("tor_below_p", 64'h200, 8'd1, 2'd1, 1'b0, 4'h5, 16'd0, 17, 0);
        do_req("tor_in",      64'h800, 8'd1, 2'd1, 1'b1, 4'h0, 16'd1, 5,  0);

        clear_mem();
        mem[2] = mk(64'h1FF, 1'b0, 1'b1, 2'd3);
`ifdef RV_IOPMP_NAPOT_EN
        do_req("napot",      64'h3FC, 8'd1, 2'd2, 1'b1, 4'h0, 16'd2, 7,  0);
`else
        do_req("napot_off",  64'h3FC, 8'd1, 2'd2, 1'b0, 4'h5, 16'd0, 17, 0);
`endif

        // Reset while the walk is in EVAL: request abandoned, no response
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_addr_i  = 64'h800;
        req_rid_i   = 8'd0;
        req_ttype_i = 2'd1;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        rst_ni = 1'b0;
        @(posedge clk_i); #1;
        check("midrst:rsp_valid", 64'(rsp_valid_o), 64'd0);
        check("midrst:bram_en", 64'(bram_en_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        check("midrst:idle", 64'(req_ready_o), 64'd1);
`ifdef RV_IOPMP_NAPOT_EN
        do_req("post_rst",   64'h3FC, 8'd1, 2'd2, 1'b1, 4'h0, 16'd2, 7,  0);
`else
        do_req("post_rst",   64'h3FC, 8'd1, 2'd2, 1'b0, 4'h5, 16'd0, 17, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
